operand_stage: RTL and testbench

- Decode/operand-fetch stage of the 5-stage RV32I pipeline.
- Takes the IF/ID instruction and drives the register-file read addresses.
- Merges same-cycle writeback data into the operands, builds the immediate, detects load-use hazards, and holds the ID/EX pipeline register consumed by the execute stage.

---
 rtl/operand_stage.sv | 147 ++++++++++++++
 tb/tb_operand_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stage.sv
// Decode / operand-fetch stage of the 5-stage RV32I pipeline.
// Builds operands and immediate, detects load-use hazards and holds the ID/EX register.
module operand_stage #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [31:0]     id_instr,
    input  logic            flush,
    output logic            stall_out,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_instr,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_imm,
    output logic            ex_reg_write,
    output logic            ex_is_load,
    output logic [31:0]     stall_cnt
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            reg_write;
    logic            is_load;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            hazard;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign rf_rs1 = id_instr[19:15];
    assign rf_rs2 = id_instr[24:20];

    always_comb begin
        uses_rs1  = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
        uses_rs2  = (opcode == OpReg || opcode == OpStore || opcode == OpBranch);
        reg_write = (opcode == OpLui || opcode == OpAuipc || opcode == OpJal ||
                     opcode == OpJalr || opcode == OpLoad || opcode == OpImm ||
                     opcode == OpReg) && (rd != 5'd0);
        is_load   = (opcode == OpLoad);
    end

    always_comb begin
        imm32 = 32'd0;
        case (opcode)
            OpJalr, OpLoad, OpImm: imm32 = {{20{id_instr[31]}}, id_instr[31:20]};
            OpStore:  imm32 = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
            OpBranch: imm32 = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                               id_instr[30:25], id_instr[11:8], 1'b0};
            OpLui, OpAuipc: imm32 = {id_instr[31:12], 12'd0};
            OpJal:    imm32 = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                               id_instr[20], id_instr[30:21], 1'b0};
            default:  imm32 = 32'd0;
        endcase
        imm = XLEN'(signed'(imm32));
    end

    // The register file writes on the edge, so same-cycle writeback must be bypassed here.
    function automatic logic [XLEN-1:0] select_operand(input logic [4:0]      addr,
                                                       input logic [XLEN-1:0] rdata,
                                                       input logic            we,
                                                       input logic [4:0]      wrd,
                                                       input logic [XLEN-1:0] wdata);
        if (addr == 5'd0) begin
            return '0;
        end else if (we && wrd == addr) begin
            return wdata;
        end
        return rdata;
    endfunction

    always_comb begin
        op1 = select_operand(rf_rs1, rf_rdata1, wb_we, wb_rd, wb_data);
        op2 = select_operand(rf_rs2, rf_rdata2, wb_we, wb_rd, wb_data);
    end

    always_comb begin
        hazard = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                 ((uses_rs1 && rf_rs1 == ex_rd) || (uses_rs2 && rf_rs2 == ex_rd));
        stall_out = hazard && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_instr     <= NOP_INSTR;
            ex_rd        <= 5'd0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_imm       <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
            stall_cnt    <= 32'd0;
        end else if (flush || hazard) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_instr     <= NOP_INSTR;
            ex_rd        <= 5'd0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_imm       <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
            if (!flush && stall_cnt != 32'hFFFFFFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_instr     <= id_instr;
            ex_rd        <= rd;
            ex_op1       <= op1;
            ex_op2       <= op2;
            ex_imm       <= imm;
            ex_reg_write <= id_valid && reg_write;
            ex_is_load   <= id_valid && is_load;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed vector table, hand-written hazard/flush/reset
// sequences and a randomized run against a spec-level reference model.
module tb_operand_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        flush;
    logic        stall_out;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_instr, ex_op1, ex_op2, ex_imm, stall_cnt;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_is_load;

    int compared   = 0;
    int mismatched = 0;

    operand_stage #(.XLEN(32), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .flush(flush), .stall_out(stall_out), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic fl);
        id_valid = v;
        id_pc    = pc;
        id_instr = ins;
        flush    = fl;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 32'd0, NOP, 1'b0);
        rf_rdata1 = 32'd0;
        rf_rdata2 = 32'd0;
        wb_we     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [31:0] e_imm;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_ld;
    } vec_t;

    // ---------------- reference model (decode from the ISA rules) ----------------
    typedef struct {
        logic        valid;
        logic        bubble;
        logic [31:0] pc, instr, op1, op2, imm;
        logic [4:0]  rd;
        logic        rw, ld;
    } ex_t;

    ex_t         m;
    logic [31:0] m_cnt;

    function automatic void ref_decode(input logic [31:0] ins, output logic u1, output logic u2,
                                       output logic rw, output logic ld,
                                       output logic [31:0] imm);
        logic [12:0] boff;
        logic [20:0] joff;
        logic [11:0] soff;
        u1 = 1'b1; u2 = 1'b0; rw = 1'b0; ld = 1'b0; imm = 32'd0;
        boff = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        joff = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        soff = {ins[31:25], ins[11:7]};
        case (ins[6:0])
            7'h37, 7'h17: begin u1 = 1'b0; rw = 1'b1; imm = {ins[31:12], 12'd0}; end
            7'h6F: begin u1 = 1'b0; rw = 1'b1; imm = 32'($signed(joff)); end
            7'h67, 7'h13: begin rw = 1'b1; imm = 32'($signed(ins[31:20])); end
            7'h03: begin rw = 1'b1; ld = 1'b1; imm = 32'($signed(ins[31:20])); end
            7'h23: begin u2 = 1'b1; imm = 32'($signed(soff)); end
            7'h63: begin u2 = 1'b1; imm = 32'($signed(boff)); end
            7'h33: begin u2 = 1'b1; rw = 1'b1; end
            default: ;
        endcase
        if (ins[11:7] == 5'd0) rw = 1'b0;
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rdata);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_rd == a) return wb_data;
        return rdata;
    endfunction

    logic [6:0] opc_list [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                                  7'h33, 7'h7B};

    initial begin
        vec_t vecs[$];
        rst = 1'b1;
        idle_inputs();

        // Reset values, checked while held and after release.
        #12;
        check("rst_held ex_valid", 32'(ex_valid), 32'd0);
        check("rst_held ex_instr", ex_instr, NOP);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset ex_valid", 32'(ex_valid), 32'd0);
        check("reset ex_instr", ex_instr, NOP);
        check("reset stall_cnt", stall_cnt, 32'd0);
        check("reset stall_out", 32'(stall_out), 32'd0);
        check("reset reg_write", 32'(ex_reg_write), 32'd0);

        // Directed decode / operand vectors.
        vecs.push_back('{"addi", 32'hFFF28313, 32'd7, 32'h55, 1'b0, 5'd0, 32'd0,
                         32'd7, 32'h55, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0});
        vecs.push_back('{"addi_x0", 32'hFFF28013, 32'd7, 32'h55, 1'b0, 5'd0, 32'd0,
                         32'd7, 32'h55, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{"addi_wbmiss", 32'hFFF28313, 32'd7, 32'h55, 1'b1, 5'd6, 32'h1234,
                         32'd7, 32'h55, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0});
        vecs.push_back('{"add_bypass", 32'h005283B3, 32'd1, 32'd2, 1'b1, 5'd5, 32'hDEADBEEF,
                         32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 5'd7, 1'b1, 1'b0});
        vecs.push_back('{"add_x0", 32'h000003B3, 32'h11, 32'h22, 1'b1, 5'd0, 32'hCAFE,
                         32'd0, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0});
        vecs.push_back('{"lw", 32'h0000A283, 32'h100, 32'h33, 1'b1, 5'd2, 32'h99,
                         32'h100, 32'd0, 32'd0, 5'd5, 1'b1, 1'b1});
        vecs.push_back('{"sw", 32'hFE20AE23, 32'h1000, 32'h2000, 1'b0, 5'd0, 32'd0,
                         32'h1000, 32'h2000, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0});
        vecs.push_back('{"beq", 32'hFE000CE3, 32'h1, 32'h2, 1'b0, 5'd0, 32'd0,
                         32'd0, 32'd0, 32'hFFFFFFF8, 5'd25, 1'b0, 1'b0});
        vecs.push_back('{"jal", 32'h001000EF, 32'hAA, 32'hBB, 1'b0, 5'd0, 32'd0,
                         32'd0, 32'hBB, 32'h00000800, 5'd1, 1'b1, 1'b0});
        vecs.push_back('{"lui", 32'h123452B7, 32'h5, 32'h6, 1'b1, 5'd3, 32'h77,
                         32'h5, 32'h77, 32'h12345000, 5'd5, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1'b1, 32'h1000 + 32'(i) * 4, vecs[i].instr, 1'b0);
            rf_rdata1 = vecs[i].rd1;
            rf_rdata2 = vecs[i].rd2;
            wb_we     = vecs[i].we;
            wb_rd     = vecs[i].wrd;
            wb_data   = vecs[i].wdata;
            #1 check({vecs[i].name, " stall"}, 32'(stall_out), 32'd0);
            @(posedge clk);
            #1;
            check({vecs[i].name, " valid"}, 32'(ex_valid), 32'd1);
            check({vecs[i].name, " instr"}, ex_instr, vecs[i].instr);
            check({vecs[i].name, " pc"}, ex_pc, 32'h1000 + 32'(i) * 4);
            check({vecs[i].name, " op1"}, ex_op1, vecs[i].e_op1);
            check({vecs[i].name, " op2"}, ex_op2, vecs[i].e_op2);
            check({vecs[i].name, " imm"}, ex_imm, vecs[i].e_imm);
            check({vecs[i].name, " rd"}, 32'(ex_rd), 32'(vecs[i].e_rd));
            check({vecs[i].name, " reg_write"}, 32'(ex_reg_write), 32'(vecs[i].e_rw));
            check({vecs[i].name, " is_load"}, 32'(ex_is_load), 32'(vecs[i].e_ld));
            @(negedge clk);
            idle_inputs();
        end

        // Load-use: lw x5 then add x7,x5,x0 -> one stall cycle.
        do_reset();
        drive(1'b1, 32'h200, 32'h0000A283, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h204, 32'h000283B3, 1'b0);
        #1 check("lu stall_out", 32'(stall_out), 32'd1);
        @(negedge clk);
        check("lu bubble valid", 32'(ex_valid), 32'd0);
        check("lu bubble instr", ex_instr, NOP);
        check("lu stall_cnt", stall_cnt, 32'd1);
        check("lu stall released", 32'(stall_out), 32'd0);
        @(negedge clk);
        check("lu add valid", 32'(ex_valid), 32'd1);
        check("lu add instr", ex_instr, 32'h000283B3);
        check("lu cnt hold", stall_cnt, 32'd1);

        // lw x5 then lui x6 whose rs1 field is 5: no dependency, no stall.
        drive(1'b1, 32'h208, 32'h0000A283, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h20C, 32'h00028337, 1'b0);
        #1 check("lui no stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        check("lui enters", ex_instr, 32'h00028337);
        check("lui cnt", stall_cnt, 32'd1);

        // Flush together with a hazard.
        drive(1'b1, 32'h210, 32'h0000A283, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h214, 32'h000283B3, 1'b1);
        #1 check("flush stall_out", 32'(stall_out), 32'd0);
        @(negedge clk);
        check("flush valid", 32'(ex_valid), 32'd0);
        check("flush instr", ex_instr, NOP);
        check("flush cnt", stall_cnt, 32'd1);

        // Asynchronous reset mid-stream.
        drive(1'b1, 32'h218, 32'hFFF28313, 1'b0);
        @(negedge clk);
        check("pre-arst valid", 32'(ex_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst valid", 32'(ex_valid), 32'd0);
        check("arst instr", ex_instr, NOP);
        check("arst cnt", stall_cnt, 32'd0);
        check("arst stall_out", 32'(stall_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        // Randomized run against the reference model.
        m = '{valid: 1'b0, bubble: 1'b1, pc: 32'd0, instr: NOP, op1: 32'd0, op2: 32'd0,
              imm: 32'd0, rd: 5'd0, rw: 1'b0, ld: 1'b0};
        m_cnt = 32'd0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic u1, u2, rw, ld, haz;
            logic [31:0] imm;
            @(negedge clk);
            ins = $urandom;
            ins[6:0]   = opc_list[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, $urandom, ins, $urandom_range(0, 7) == 0);
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            wb_we     = 1'($urandom);
            wb_rd     = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            ref_decode(ins, u1, u2, rw, ld, imm);
            haz = id_valid && m.valid && m.ld && m.rd != 5'd0 &&
                  ((u1 && ins[19:15] == m.rd) || (u2 && ins[24:20] == m.rd));
            #1;
            check("rnd rs1", 32'(rf_rs1), 32'(ins[19:15]));
            check("rnd rs2", 32'(rf_rs2), 32'(ins[24:20]));
            check("rnd stall_out", 32'(stall_out), 32'(haz && !flush));
            if (flush || haz) begin
                m.valid = 1'b0; m.bubble = 1'b1; m.instr = NOP; m.rw = 1'b0; m.ld = 1'b0;
                m.rd = 5'd0;
                if (!flush && m_cnt != 32'hFFFFFFFF) m_cnt++;
            end else begin
                m = '{valid: id_valid, bubble: 1'b0, pc: id_pc, instr: ins,
                      op1: ref_operand(ins[19:15], rf_rdata1),
                      op2: ref_operand(ins[24:20], rf_rdata2), imm: imm, rd: ins[11:7],
                      rw: rw && id_valid, ld: ld && id_valid};
            end
            @(posedge clk);
            #1;
            check("rnd valid", 32'(ex_valid), 32'(m.valid));
            check("rnd instr", ex_instr, m.instr);
            check("rnd reg_write", 32'(ex_reg_write), 32'(m.rw));
            check("rnd is_load", 32'(ex_is_load), 32'(m.ld));
            check("rnd stall_cnt", stall_cnt, m_cnt);
            if (!m.bubble) begin
                check("rnd pc", ex_pc, m.pc);
                check("rnd rd", 32'(ex_rd), 32'(m.rd));
                check("rnd op1", ex_op1, m.op1);
                check("rnd op2", ex_op2, m.op2);
                check("rnd imm", ex_imm, m.imm);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
